ex_mem_req: RTL and testbench

- Memory-request issuer between EX and ME stages; the request-side counterpart of the ME-stage load extractor.
- Accepts one load/store op per handshake from EX and checks alignment.
- Drives a class-SRAM bus (req/addr_ok/data_ok) with size, byte strobes and lane-replicated store data.
- Returns raw read data plus the 5-bit load-format flag {sign, byte, half, off[1:0]} to ME, which sign/zero-extends.

---
 rtl/ex_mem_req_pkg.sv | 30 +++
 rtl/mem_lane_fmt.sv | 53 +++++
 rtl/ex_mem_req.sv | 248 ++++++++++++++++++++++++
 tb/tb_ex_mem_req.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_req_pkg.sv
// Shared encodings for the EX->ME memory request path: transfer sizes, FSM states,
// load-format flag width and the alignment rule.
package ex_mem_req_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LD_FLAG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Size 3 has no legal transfer, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: byte strobes, replicated store data, load-format flag
// and alignment check from size/sign/address offset.
module mem_lane_fmt
    import ex_mem_req_pkg::*;
(
    input  logic                 is_store,
    input  logic [1:0]           size,
    input  logic                 sign,
    input  logic [1:0]           off,
    input  logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic [31:0]          wdata_rep,
    output logic [LD_FLAG_W-1:0] ld_flag,
    output logic                 ale
);

    logic [3:0]           strb_base_s;
    logic [LD_FLAG_W-1:0] flag_s;

    // Per-size lane pattern before shifting to the addressed byte.
    always_comb begin
        strb_base_s = 4'b0000;
        wdata_rep   = wdata;
        flag_s      = 5'b00000;
        case (size)
            SZ_B: begin
                strb_base_s = 4'b0001;
                wdata_rep   = {4{wdata[7:0]}};
                flag_s      = {sign, 1'b1, 1'b0, off};
            end
            SZ_H: begin
                strb_base_s = 4'b0011;
                wdata_rep   = {2{wdata[15:0]}};
                flag_s      = {sign, 1'b0, 1'b1, off};
            end
            SZ_W: begin
                strb_base_s = 4'b1111;
                wdata_rep   = wdata;
                flag_s      = 5'b00000;
            end
            default: begin
                strb_base_s = 4'b0000;
                wdata_rep   = wdata;
                flag_s      = 5'b00000;
            end
        endcase
    end

    assign wstrb   = is_store ? (strb_base_s << off) : 4'b0000;
    assign ld_flag = is_store ? 5'b00000 : flag_s;
    assign ale     = is_misaligned(size, off);

endmodule

// File: rtl/ex_mem_req.sv
// EX->ME memory request issuer driving a req/addr_ok/data_ok SRAM bus.
// Optional performance counters are enabled with the macro EX_MEM_REQ_PERF_EN.
module ex_mem_req
    import ex_mem_req_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DROP_W = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_is_store,
    input  logic [1:0]           in_size,
    input  logic                 in_sign,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_wdata,
    input  logic                 flush,
    output logic                 data_sram_req,
    output logic                 data_sram_wr,
    output logic [1:0]           data_sram_size,
    output logic [3:0]           data_sram_wstrb,
    output logic [ADDR_W-1:0]    data_sram_addr,
    output logic [DATA_W-1:0]    data_sram_wdata,
    input  logic                 data_sram_addr_ok,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_rdata,
    output logic [LD_FLAG_W-1:0] out_ld_flag,
    output logic                 out_ale,
    output logic                 busy
`ifdef EX_MEM_REQ_PERF_EN
    ,
    output logic [31:0]          perf_req_cnt,
    output logic [31:0]          perf_wait_cnt,
    output logic [31:0]          perf_drop_cnt
`endif
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 wr_q, wr_d;
    logic [1:0]           size_q, size_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [LD_FLAG_W-1:0] ld_flag_q, ld_flag_d;
    logic                 ale_q, ale_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                 accept_s;
    logic                 drop_inc_s;
    logic                 drop_dec_s;
    logic                 discard_s;
    logic [3:0]           fmt_wstrb_s;
    logic [31:0]          fmt_wdata_s;
    logic [LD_FLAG_W-1:0] fmt_flag_s;
    logic                 fmt_ale_s;

    mem_lane_fmt u_fmt (
        .is_store  (in_is_store),
        .size      (in_size),
        .sign      (in_sign),
        .off       (in_addr[1:0]),
        .wdata     (in_wdata),
        .wstrb     (fmt_wstrb_s),
        .wdata_rep (fmt_wdata_s),
        .ld_flag   (fmt_flag_s),
        .ale       (fmt_ale_s)
    );

    assign in_ready = (state_q == ST_IDLE) && (drop_cnt_q != DROP_MAX) && !flush;
    assign accept_s = in_valid && in_ready;
    // Responses return in order, so any data_ok seen with drops pending belongs to a cancelled op.
    assign drop_dec_s = data_sram_data_ok && (drop_cnt_q != {DROP_W{1'b0}});

    // Next-state, bus-field and result computation.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        out_valid_d  = out_valid_q;
        rdata_d      = rdata_q;
        ld_flag_d    = ld_flag_q;
        ale_d        = ale_q;
        flush_pend_d = flush_pend_q;
        drop_inc_s   = 1'b0;
        discard_s    = drop_dec_s;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    wr_d         = in_is_store;
                    size_d       = in_size;
                    addr_d       = in_addr;
                    wstrb_d      = fmt_wstrb_s;
                    wdata_d      = fmt_wdata_s;
                    ld_flag_d    = fmt_flag_s;
                    rdata_d      = {DATA_W{1'b0}};
                    flush_pend_d = 1'b0;
                    if (fmt_ale_s) begin
                        ale_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        ale_d   = 1'b0;
                        req_d   = 1'b1;
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // A flushed request must still complete its address handshake before being dropped.
                if (data_sram_addr_ok) begin
                    req_d = 1'b0;
                    if (flush || flush_pend_q) begin
                        flush_pend_d = 1'b0;
                        drop_inc_s   = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    if (data_sram_data_ok && !drop_dec_s) begin
                        discard_s = 1'b1;
                    end else begin
                        drop_inc_s = 1'b1;
                    end
                end else if (data_sram_data_ok && !drop_dec_s) begin
                    rdata_d     = wr_q ? {DATA_W{1'b0}} : data_sram_rdata;
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (flush || out_ready) begin
                    out_valid_d = 1'b0;
                    ale_d       = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({drop_inc_s, drop_dec_s})
            2'b10:   drop_cnt_d = drop_cnt_q + DROP_W'(1);
            2'b01:   drop_cnt_d = drop_cnt_q - DROP_W'(1);
            default: drop_cnt_d = drop_cnt_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            wstrb_q      <= 4'b0000;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            out_valid_q  <= 1'b0;
            rdata_q      <= {DATA_W{1'b0}};
            ld_flag_q    <= 5'b00000;
            ale_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            drop_cnt_q   <= {DROP_W{1'b0}};
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            out_valid_q  <= out_valid_d;
            rdata_q      <= rdata_d;
            ld_flag_q    <= ld_flag_d;
            ale_q        <= ale_d;
            flush_pend_q <= flush_pend_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign data_sram_req   = req_q;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;
    assign out_valid       = out_valid_q;
    assign out_rdata       = rdata_q;
    assign out_ld_flag     = ld_flag_q;
    assign out_ale         = ale_q;
    assign busy            = (state_q != ST_IDLE) || (drop_cnt_q != {DROP_W{1'b0}});

`ifdef EX_MEM_REQ_PERF_EN
    logic [31:0] perf_req_q, perf_wait_q, perf_drop_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_req_q  <= 32'd0;
            perf_wait_q <= 32'd0;
            perf_drop_q <= 32'd0;
        end else begin
            perf_req_q  <= perf_req_q + ((req_q && data_sram_addr_ok) ? 32'd1 : 32'd0);
            perf_wait_q <= perf_wait_q + (((state_q == ST_ADDR) || (state_q == ST_DATA)) ? 32'd1 : 32'd0);
            perf_drop_q <= perf_drop_q + (discard_s ? 32'd1 : 32'd0);
        end
    end

    assign perf_req_cnt  = perf_req_q;
    assign perf_wait_cnt = perf_wait_q;
    assign perf_drop_cnt = perf_drop_q;
`else
    logic unused_s;
    assign unused_s = discard_s;
`endif

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed testbench for ex_mem_req: table of single-op vectors plus hand-written
// sequences for latency, flush/drop, back-pressure, RESP flush and mid-transaction reset.
module tb_ex_mem_req;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_sign;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_ld_flag;
    logic        out_ale;
    logic        busy;
`ifdef EX_MEM_REQ_PERF_EN
    logic [31:0] perf_req_cnt, perf_wait_cnt, perf_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ex_mem_req dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_is_store       (in_is_store),
        .in_size           (in_size),
        .in_sign           (in_sign),
        .in_addr           (in_addr),
        .in_wdata          (in_wdata),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_rdata         (out_rdata),
        .out_ld_flag       (out_ld_flag),
        .out_ale           (out_ale),
        .busy              (busy)
`ifdef EX_MEM_REQ_PERF_EN
        ,
        .perf_req_cnt      (perf_req_cnt),
        .perf_wait_cnt     (perf_wait_cnt),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [4:0]  e_flag;
        logic [31:0] e_rdata;
        logic        e_ale;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        in_valid    = 1'b1;
        in_is_store = st;
        in_size     = sz;
        in_sign     = sg;
        in_addr     = addr;
        in_wdata    = wd;
        #1;
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.st, v.sz, v.sg, v.addr, v.wd);
        if (v.e_ale) begin
            chk("ale_flag", {31'd0, out_ale}, 32'd1);
            chk("ale_valid", {31'd0, out_valid}, 32'd1);
            chk("ale_noreq", {31'd0, data_sram_req}, 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("ale_busy", {31'd0, busy}, 32'd0);
            chk("ale_noreq2", {31'd0, data_sram_req}, 32'd0);
        end else begin
            chk("req", {31'd0, data_sram_req}, 32'd1);
            chk("wr", {31'd0, data_sram_wr}, {31'd0, v.st});
            chk("size", {30'd0, data_sram_size}, {30'd0, v.sz});
            chk("addr", data_sram_addr, v.addr);
            chk("wstrb", {28'd0, data_sram_wstrb}, {28'd0, v.e_strb});
            chk("wdata", data_sram_wdata, v.e_wdata);
            data_sram_addr_ok = 1'b1;
            tick();
            data_sram_addr_ok = 1'b0;
            chk("req_drop", {31'd0, data_sram_req}, 32'd0);
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = v.rd;
            tick();
            data_sram_data_ok = 1'b0;
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_rdata", out_rdata, v.e_rdata);
            chk("out_ld_flag", {27'd0, out_ld_flag}, {27'd0, v.e_flag});
            chk("out_ale0", {31'd0, out_ale}, 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("done_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        //            st    sz    sg    addr          wd            rd            strb     wdata         flag      rdata         ale
        vecs[0] = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'hAB00_0000, 4'b0000, 32'h0000_0000, 5'b11011, 32'hAB00_0000, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 4'b1100, 32'hABCD_ABCD, 5'b00000, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 5'b00000, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00EE, 32'h0000_0000, 4'b0010, 32'hEEEE_EEEE, 5'b00000, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h1234_0000, 4'b0000, 32'h0000_0000, 5'b00110, 32'h1234_0000, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_BABE, 32'h0000_0000, 4'b1111, 32'hCAFE_BABE, 5'b00000, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, 2'd2, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h89AB_CDEF, 4'b0000, 32'h1111_1111, 5'b00000, 32'h89AB_CDEF, 1'b0};
        vecs[7] = '{1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 5'b00000, 32'h0000_0000, 1'b1};
        vecs[8] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 5'b00000, 32'h0000_0000, 1'b1};
        vecs[9] = '{1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0080, 4'b0000, 32'h0000_0000, 5'b01000, 32'h0000_0080, 1'b0};

        resetn            = 1'b0;
        in_valid          = 1'b0;
        in_is_store       = 1'b0;
        in_size           = 2'd0;
        in_sign           = 1'b0;
        in_addr           = 32'd0;
        in_wdata          = 32'd0;
        flush             = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        out_ready         = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, data_sram_req}, 32'd0);
        chk("rst_wr", {31'd0, data_sram_wr}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ale", {31'd0, out_ale}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", out_rdata, 32'd0);
        chk("rst_flag", {27'd0, out_ld_flag}, 32'd0);
        chk("rst_addr", data_sram_addr, 32'd0);
        chk("rst_wdata", data_sram_wdata, 32'd0);
        chk("rst_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
        chk("rst_size", {30'd0, data_sram_size}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Latency: accept c0, addr_ok c2, data_ok c4, out_valid c5.
        issue(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0000_0000);
        chk("lat_c1_req", {31'd0, data_sram_req}, 32'd1);
        tick();
        data_sram_addr_ok = 1'b1;
        chk("lat_c2_req", {31'd0, data_sram_req}, 32'd1);
        tick();
        data_sram_addr_ok = 1'b0;
        chk("lat_c3_req", {31'd0, data_sram_req}, 32'd0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAB00_0000;
        chk("lat_c4_valid", {31'd0, out_valid}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        chk("lat_c5_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_c5_rdata", out_rdata, 32'hAB00_0000);
        chk("lat_c5_flag", {27'd0, out_ld_flag}, {27'd0, 5'b11011});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush in ADDR: request held until addr_ok, then one response dropped.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0000_0000);
        chk("fl_req", {31'd0, data_sram_req}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl_req_held", {31'd0, data_sram_req}, 32'd1);
            chk("fl_addr_held", data_sram_addr, 32'h0000_0040);
            if (i == 2) data_sram_addr_ok = 1'b1;
            tick();
        end
        data_sram_addr_ok = 1'b0;
        chk("fl_req_off", {31'd0, data_sram_req}, 32'd0);
        chk("fl_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_busy_drop", {31'd0, busy}, 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0000_0000);
        chk("fl2_addr", data_sram_addr, 32'h0000_0044);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        tick();
        data_sram_rdata = 32'h0000_BEEF;
        chk("fl2_dropped", {31'd0, out_valid}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        chk("fl2_valid", {31'd0, out_valid}, 32'd1);
        chk("fl2_rdata", out_rdata, 32'h0000_BEEF);

        // Back-pressure in RESP for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_rdata", out_rdata, 32'h0000_BEEF);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd0);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush in RESP drops the result.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0000_0000);
        chk("rf_ale", {31'd0, out_ale}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rf_valid", {31'd0, out_valid}, 32'd0);
        chk("rf_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in DATA.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0050, 32'h0000_0000);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        chk("ar_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_req", {31'd0, data_sram_req}, 32'd0);
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("ar_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_busy_post", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
